// File: rtl/axis_i2c_arbiter.sv
`default_nettype none
// ============================================================================
// axis_i2c_arbiter : round-robin packet arbiter in front of one axis_i2c_master
// Revision: 1.0
// ============================================================================
module axis_i2c_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 16,
    parameter int RSP_WIDTH  = 8,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,

    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata_i,
    input  logic [NUM_REQ-1:0]            req_tvalid_i,
    input  logic [NUM_REQ-1:0]            req_tlast_i,
    input  logic [NUM_REQ-1:0]            req_tuser_i,
    output logic [NUM_REQ-1:0]            req_tready_o,

    output logic [DATA_WIDTH-1:0]         m_tdata_o,
    output logic                          m_tvalid_o,
    output logic                          m_tlast_o,
    input  logic                          m_tready_i,

    input  logic [RSP_WIDTH-1:0]          s_tdata_i,
    input  logic                          s_tvalid_i,
    input  logic                          s_tlast_i,
    output logic                          s_tready_o,

    output logic [NUM_REQ*RSP_WIDTH-1:0]  rsp_tdata_o,
    output logic [NUM_REQ-1:0]            rsp_tvalid_o,
    output logic [NUM_REQ-1:0]            rsp_tlast_o,
    input  logic [NUM_REQ-1:0]            rsp_tready_i,

    output logic [IDX_W-1:0]              owner_o,
    output logic                          busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             rd_q, rd_d;

    logic [IDX_W-1:0] winner;
    logic [IDX_W:0]   cand;
    logic             found;

    // First valid index strictly after last_q, wrapping modulo NUM_REQ.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_q} + (IDX_W+1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!found && req_tvalid_i[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        rd_d         = rd_q;
        m_tdata_o    = '0;
        m_tvalid_o   = 1'b0;
        m_tlast_o    = 1'b0;
        req_tready_o = '0;
        s_tready_o   = 1'b0;
        rsp_tdata_o  = '0;
        rsp_tvalid_o = '0;
        rsp_tlast_o  = '0;

        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                m_tdata_o = req_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        case (state_q)
            IDLE: begin
                if (|req_tvalid_i) begin
                    state_d = REQ;
                    owner_d = winner;
                    last_d  = winner;
                    rd_d    = req_tuser_i[winner];
                end
            end
            REQ: begin
                m_tvalid_o            = req_tvalid_i[owner_q];
                m_tlast_o             = req_tlast_i[owner_q];
                req_tready_o[owner_q] = m_tready_i;
                if (req_tvalid_i[owner_q] && m_tready_i && req_tlast_i[owner_q]) begin
                    state_d = rd_q ? RSP : IDLE;
                end
            end
            RSP: begin
                s_tready_o = rsp_tready_i[owner_q];
                // Only the owner's slice carries the response; others stay zero.
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (owner_q == IDX_W'(k)) begin
                        rsp_tdata_o[k*RSP_WIDTH +: RSP_WIDTH] = s_tdata_i;
                        rsp_tvalid_o[k]                       = s_tvalid_i;
                        rsp_tlast_o[k]                        = s_tlast_i;
                    end
                end
                if (s_tvalid_i && rsp_tready_i[owner_q] && s_tlast_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign owner_o = owner_q;
    assign busy_o  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_i2c_arbiter.sv
`default_nettype none
// Bench for axis_i2c_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of grant, packet and response routing.
module tb_axis_i2c_arbiter;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int RW = 8;

    logic            clk = 1'b0;
    logic            arstn = 1'b0;
    logic [N*DW-1:0] req_tdata;
    logic [N-1:0]    req_tvalid, req_tlast, req_tuser, req_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid, m_tlast, m_tready;
    logic [RW-1:0]   s_tdata;
    logic            s_tvalid, s_tlast, s_tready;
    logic [N*RW-1:0] rsp_tdata;
    logic [N-1:0]    rsp_tvalid, rsp_tlast, rsp_tready;
    logic [1:0]      owner;
    logic            busy;

    int errors = 0;
    int checks = 0;

    axis_i2c_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .RSP_WIDTH(RW)) dut (
        .clk_i(clk), .arstn_i(arstn),
        .req_tdata_i(req_tdata), .req_tvalid_i(req_tvalid), .req_tlast_i(req_tlast),
        .req_tuser_i(req_tuser), .req_tready_o(req_tready),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .m_tready_i(m_tready),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
        .rsp_tdata_o(rsp_tdata), .rsp_tvalid_o(rsp_tvalid), .rsp_tlast_o(rsp_tlast),
        .rsp_tready_i(rsp_tready),
        .owner_o(owner), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req_tdata  = '0; req_tvalid = '0; req_tlast = '0; req_tuser = '0;
        m_tready   = 1'b0;
        s_tdata    = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        rsp_tready = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        arstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        arstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        arstn = 1'b0;
        #2;
        checks++;
        if ({busy, owner, req_tready, m_tvalid, s_tready, rsp_tvalid} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {busy, owner, req_tready, m_tvalid, s_tready, rsp_tvalid}, 11'b0);
        end
        req_tvalid = 3'b111;
        @(posedge clk); #1;
        checks++;
        if ({busy, m_tvalid, req_tready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", {busy, m_tvalid, req_tready}, 5'b0);
        end
        @(negedge clk);
        idle_inputs();
        arstn = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        req_tvalid = 3'b010; req_tdata[DW +: DW] = 16'hA010; req_tlast = 3'b000; m_tready = 1'b1;
        #1;
        checks++;
        if ({busy, m_tvalid} !== 2'b00) begin
            errors++; $display("FAIL write_pre_grant: got %b expected %b", {busy, m_tvalid}, 2'b00);
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, owner, req_tready, m_tvalid, m_tdata, m_tlast} !== {1'b1, 2'd1, 3'b010, 1'b1, 16'hA010, 1'b0}) begin
            errors++;
            $display("FAIL write_beat1: got %h expected %h", {busy, owner, req_tready, m_tvalid, m_tdata, m_tlast},
                     {1'b1, 2'd1, 3'b010, 1'b1, 16'hA010, 1'b0});
        end
        @(negedge clk);
        req_tdata[DW +: DW] = 16'hA020; req_tlast = 3'b010;
        #1;
        checks++;
        if ({busy, owner, m_tvalid, m_tdata, m_tlast} !== {1'b1, 2'd1, 1'b1, 16'hA020, 1'b1}) begin
            errors++;
            $display("FAIL write_beat2: got %h expected %h", {busy, owner, m_tvalid, m_tdata, m_tlast},
                     {1'b1, 2'd1, 1'b1, 16'hA020, 1'b1});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if ({busy, req_tready, m_tvalid} !== 5'b0) begin
            errors++; $display("FAIL write_release: got %b expected %b", {busy, req_tready, m_tvalid}, 5'b0);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        req_tvalid = 3'b111; req_tlast = 3'b111; m_tready = 1'b1;
        for (int k = 0; k < N; k++) req_tdata[k*DW +: DW] = 16'hB000 + 16'(k);
        for (int g = 0; g < N; g++) begin
            @(negedge clk); #1;
            checks++;
            if ({busy, owner, req_tready, m_tdata} !== {1'b1, 2'(g), 3'(1 << g), 16'hB000 + 16'(g)}) begin
                errors++;
                $display("FAIL rr_grant%0d: got %h expected %h", g, {busy, owner, req_tready, m_tdata},
                         {1'b1, 2'(g), 3'(1 << g), 16'hB000 + 16'(g)});
            end
            @(negedge clk);
            req_tvalid[g] = 1'b0;
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL rr_idle%0d: got %b expected 0", g, busy);
            end
        end
        @(negedge clk);
        req_tvalid = 3'b001;
        @(negedge clk); #1;
        checks++;
        if ({busy, owner, req_tready} !== {1'b1, 2'd0, 3'b001}) begin
            errors++; $display("FAIL rr_regrant0: got %b expected %b", {busy, owner, req_tready}, {1'b1, 2'd0, 3'b001});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_read();
        do_reset();
        @(negedge clk);
        req_tvalid = 3'b011; req_tlast = 3'b011; req_tuser = 3'b001;
        req_tdata[0 +: DW] = 16'h0A00; req_tdata[DW +: DW] = 16'h1111;
        m_tready = 1'b1; rsp_tready = 3'b001;
        @(negedge clk); #1;
        checks++;
        if ({busy, owner, req_tready, m_tvalid, m_tdata} !== {1'b1, 2'd0, 3'b001, 1'b1, 16'h0A00}) begin
            errors++; $display("FAIL read_req: got %h expected %h", {busy, owner, req_tready, m_tvalid, m_tdata},
                               {1'b1, 2'd0, 3'b001, 1'b1, 16'h0A00});
        end
        @(negedge clk);
        req_tvalid[0] = 1'b0; req_tuser = '0;
        #1;
        checks++;
        if ({busy, owner, req_tready, m_tvalid, s_tready, rsp_tvalid} !== {1'b1, 2'd0, 3'b000, 1'b0, 1'b1, 3'b000}) begin
            errors++; $display("FAIL read_rsp_wait: got %b expected %b", {busy, owner, req_tready, m_tvalid, s_tready, rsp_tvalid},
                               {1'b1, 2'd0, 3'b000, 1'b0, 1'b1, 3'b000});
        end
        s_tvalid = 1'b1; s_tdata = 8'h5A; s_tlast = 1'b0; rsp_tready = 3'b000;
        #1;
        checks++;
        if ({s_tready, rsp_tvalid, rsp_tdata[0 +: RW]} !== {1'b0, 3'b001, 8'h5A}) begin
            errors++; $display("FAIL read_rsp_stall: got %h expected %h", {s_tready, rsp_tvalid, rsp_tdata[0 +: RW]},
                               {1'b0, 3'b001, 8'h5A});
        end
        @(negedge clk);
        rsp_tready = 3'b001;
        #1;
        checks++;
        if ({busy, s_tready, rsp_tvalid, rsp_tlast, rsp_tdata[0 +: RW]} !== {1'b1, 1'b1, 3'b001, 3'b000, 8'h5A}) begin
            errors++; $display("FAIL read_rsp_beat1: got %h expected %h", {busy, s_tready, rsp_tvalid, rsp_tlast, rsp_tdata[0 +: RW]},
                               {1'b1, 1'b1, 3'b001, 3'b000, 8'h5A});
        end
        @(negedge clk);
        s_tdata = 8'hC3; s_tlast = 1'b1;
        #1;
        checks++;
        if ({busy, req_tready, rsp_tvalid, rsp_tlast, rsp_tdata[0 +: RW]} !== {1'b1, 3'b000, 3'b001, 3'b001, 8'hC3}) begin
            errors++; $display("FAIL read_rsp_beat2: got %h expected %h", {busy, req_tready, rsp_tvalid, rsp_tlast, rsp_tdata[0 +: RW]},
                               {1'b1, 3'b000, 3'b001, 3'b001, 8'hC3});
        end
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        checks++;
        if ({busy, req_tready, rsp_tvalid} !== 7'b0) begin
            errors++; $display("FAIL read_release: got %b expected %b", {busy, req_tready, rsp_tvalid}, 7'b0);
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, owner, req_tready, m_tdata} !== {1'b1, 2'd1, 3'b010, 16'h1111}) begin
            errors++; $display("FAIL read_next_owner: got %h expected %h", {busy, owner, req_tready, m_tdata},
                               {1'b1, 2'd1, 3'b010, 16'h1111});
        end
        @(negedge clk);
        req_tvalid = '0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL read_write_done: got %b expected 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        logic [DW-1:0] beats [3];
        int idx;
        logic mtr, vld;
        beats[0] = 16'hC001; beats[1] = 16'hC002; beats[2] = 16'hC003;
        idx = 0;
        @(negedge clk);
        req_tvalid = 3'b101; req_tlast = 3'b001;
        req_tdata[0 +: DW] = 16'hEEEE; req_tdata[2*DW +: DW] = beats[0];
        for (int cyc = 0; cyc < 20 && idx < 3; cyc++) begin
            @(negedge clk);
            mtr = (cyc % 2 == 0);
            vld = !(cyc == 2 || cyc == 3);
            m_tready = mtr; req_tvalid[2] = vld;
            req_tdata[2*DW +: DW] = beats[idx]; req_tlast[2] = (idx == 2);
            #1;
            checks++;
            if ({busy, owner, req_tready, m_tvalid} !== {1'b1, 2'd2, mtr, 2'b00, vld}) begin
                errors++; $display("FAIL stall_ctrl cyc%0d: got %b expected %b", cyc, {busy, owner, req_tready, m_tvalid},
                                   {1'b1, 2'd2, mtr, 2'b00, vld});
            end
            if (vld) begin
                checks++;
                if ({m_tdata, m_tlast} !== {beats[idx], idx == 2}) begin
                    errors++; $display("FAIL stall_data cyc%0d: got %h expected %h", cyc, {m_tdata, m_tlast}, {beats[idx], idx == 2});
                end
            end
            if (vld && mtr) idx++;
        end
        checks++;
        if (idx != 3) begin
            errors++; $display("FAIL stall_timeout: got %0d beats expected 3", idx);
        end
        @(negedge clk);
        req_tvalid[2] = 1'b0; m_tready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL stall_release: got %b expected 0", busy);
        end
        @(negedge clk); #1;
        checks++;
        if ({busy, owner, m_tdata} !== {1'b1, 2'd0, 16'hEEEE}) begin
            errors++; $display("FAIL stall_next: got %h expected %h", {busy, owner, m_tdata}, {1'b1, 2'd0, 16'hEEEE});
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_tvalid = 3'b010; req_tlast = 3'b000; req_tdata[DW +: DW] = 16'hD001; m_tready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, owner, m_tdata} !== {1'b1, 2'd1, 16'hD001}) begin
            errors++; $display("FAIL rstmid_grant: got %h expected %h", {busy, owner, m_tdata}, {1'b1, 2'd1, 16'hD001});
        end
        @(negedge clk);
        req_tdata[DW +: DW] = 16'hD002; req_tvalid = 3'b011;
        req_tdata[0 +: DW] = 16'hD0F0; req_tlast = 3'b001;
        #1;
        checks++;
        if ({owner, req_tready, m_tdata} !== {2'd1, 3'b010, 16'hD002}) begin
            errors++; $display("FAIL rstmid_beat2: got %h expected %h", {owner, req_tready, m_tdata}, {2'd1, 3'b010, 16'hD002});
        end
        #1 arstn = 1'b0;
        #1;
        checks++;
        if ({busy, owner, req_tready, m_tvalid, s_tready, rsp_tvalid} !== 11'b0) begin
            errors++; $display("FAIL rstmid_async: got %b expected %b",
                               {busy, owner, req_tready, m_tvalid, s_tready, rsp_tvalid}, 11'b0);
        end
        @(negedge clk);
        arstn = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({busy, owner, req_tready, m_tdata} !== {1'b1, 2'd0, 3'b001, 16'hD0F0}) begin
            errors++; $display("FAIL rstmid_first_grant: got %h expected %h", {busy, owner, req_tready, m_tdata},
                               {1'b1, 2'd0, 3'b001, 16'hD0F0});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_done: got %b expected 0", busy);
        end
    endtask

    task automatic test_rsp_idle();
        @(negedge clk);
        idle_inputs();
        s_tvalid = 1'b1; s_tdata = 8'h77; s_tlast = 1'b1; rsp_tready = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({busy, s_tready, rsp_tvalid} !== 5'b0) begin
                errors++; $display("FAIL rsp_idle%0d: got %b expected %b", c, {busy, s_tready, rsp_tvalid}, 5'b0);
            end
        end
        idle_inputs();
    endtask

    // Model: phase 0 = no grant, 1 = request packet, 2 = awaiting read response.
    task automatic test_random();
        int            m_phase, m_owner, m_last, pick;
        logic          m_rd;
        int            r_act [N];
        int            r_left [N];
        logic          r_rd [N], r_lst [N], r_usr [N], r_first [N];
        logic [DW-1:0] r_dat [N];
        logic [8:0]    rq [$];
        logic [2:0]    e_ready, e_rv;
        logic          e_mval, e_sr;
        do_reset();
        m_phase = 0; m_owner = 0; m_last = N - 1; m_rd = 1'b0;
        for (int k = 0; k < N; k++) begin
            r_act[k] = 0; r_left[k] = 0; r_rd[k] = 0; r_lst[k] = 0; r_usr[k] = 0; r_first[k] = 0; r_dat[k] = '0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (r_act[k] == 0) begin
                    if (r_left[k] == 0 && $urandom_range(2) == 0) begin
                        r_left[k]  = int'($urandom_range(3, 1));
                        r_rd[k]    = ($urandom_range(2) == 0);
                        r_first[k] = 1'b1;
                    end
                    if (r_left[k] > 0) begin
                        r_act[k] = 1;
                        r_dat[k] = 16'($urandom);
                        r_lst[k] = (r_left[k] == 1);
                        r_usr[k] = r_first[k] ? r_rd[k] : 1'($urandom);
                    end
                end
                req_tvalid[k]        = (r_act[k] != 0) && ($urandom_range(3) != 0);
                req_tdata[k*DW +: DW] = r_dat[k];
                req_tlast[k]         = r_lst[k];
                req_tuser[k]         = r_usr[k];
            end
            rsp_tready = 3'($urandom);
            m_tready   = 1'($urandom);
            if (rq.size() > 0 && $urandom_range(3) != 0) begin
                s_tvalid = 1'b1; s_tdata = rq[0][7:0]; s_tlast = rq[0][8];
            end else begin
                s_tvalid = 1'b0; s_tdata = 8'($urandom); s_tlast = 1'b0;
            end
            #1;
            e_ready = (m_phase == 1 && m_tready) ? 3'(1 << m_owner) : 3'b000;
            e_mval  = (m_phase == 1) && req_tvalid[m_owner];
            e_sr    = (m_phase == 2) && rsp_tready[m_owner];
            e_rv    = (m_phase == 2 && s_tvalid) ? 3'(1 << m_owner) : 3'b000;
            checks++;
            if ({busy, req_tready, m_tvalid, s_tready, rsp_tvalid} !== {m_phase != 0, e_ready, e_mval, e_sr, e_rv}) begin
                errors++; $display("FAIL rand_ctrl cyc%0d: got %b expected %b", cyc,
                                   {busy, req_tready, m_tvalid, s_tready, rsp_tvalid}, {m_phase != 0, e_ready, e_mval, e_sr, e_rv});
            end
            if (m_phase != 0) begin
                checks++;
                if (owner !== 2'(m_owner)) begin
                    errors++; $display("FAIL rand_owner cyc%0d: got %0d expected %0d", cyc, owner, m_owner);
                end
            end
            if (e_mval) begin
                checks++;
                if ({m_tdata, m_tlast} !== {r_dat[m_owner], r_lst[m_owner]}) begin
                    errors++; $display("FAIL rand_mdata cyc%0d: got %h expected %h", cyc, {m_tdata, m_tlast}, {r_dat[m_owner], r_lst[m_owner]});
                end
            end
            if (e_rv != 3'b000) begin
                checks++;
                if ({rsp_tdata[m_owner*RW +: RW], rsp_tlast[m_owner]} !== {s_tdata, s_tlast}) begin
                    errors++; $display("FAIL rand_rsp cyc%0d: got %h expected %h", cyc,
                                       {rsp_tdata[m_owner*RW +: RW], rsp_tlast[m_owner]}, {s_tdata, s_tlast});
                end
            end
            case (m_phase)
                0: begin
                    pick = -1;
                    for (int i = 1; i <= N; i++) begin
                        if (pick < 0 && req_tvalid[(m_last + i) % N]) pick = (m_last + i) % N;
                    end
                    if (pick >= 0) begin
                        m_owner = pick; m_last = pick; m_rd = req_tuser[pick]; m_phase = 1;
                    end
                end
                1: begin
                    if (req_tvalid[m_owner] && m_tready) begin
                        r_act[m_owner] = 0; r_left[m_owner]--; r_first[m_owner] = 1'b0;
                        if (r_lst[m_owner]) begin
                            if (m_rd) begin
                                pick = int'($urandom_range(3, 1));
                                for (int b = 0; b < pick; b++) rq.push_back({b == pick - 1, 8'($urandom)});
                                m_phase = 2;
                            end else begin
                                m_phase = 0;
                            end
                        end
                    end
                end
                default: begin
                    if (s_tvalid && rsp_tready[m_owner]) begin
                        void'(rq.pop_front());
                        if (s_tlast) m_phase = 0;
                    end
                end
            endcase
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_read();
        test_stall();
        test_reset_mid();
        test_rsp_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axis_i2c_arbiter.md
# axis_i2c_arbiter

Round-robin arbiter that shares one `axis_i2c_master` between `NUM_REQ` AXI-Stream requesters, such as the config-ROM data generator and a runtime register port. It locks the grant for a whole request packet. For read packets it also holds the grant through the matching response packet, and routes the response back to the owning requester only. It sits in the `i2c_clk` domain, between the requesters and the master's `s_axis`/`m_axis`.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..8.
- `DATA_WIDTH`, 16: request beat width, matching the master's `s_axis`.
- `RSP_WIDTH`, 8: response beat width, matching the master's `m_axis`.
- `clk_i` in 1: single clock (`i2c_clk`).
- `arstn_i` in 1: asynchronous active-low reset.
- `req_tdata_i` in NUM_REQ*DATA_WIDTH: request data; requester k occupies slice k.
- `req_tvalid_i` in NUM_REQ: request valid, one bit per requester.
- `req_tlast_i` in NUM_REQ: last beat of a request packet.
- `req_tuser_i` in NUM_REQ: read flag, sampled on the first beat of a packet only.
- `req_tready_o` out NUM_REQ: request ready.
- `m_tdata_o` out DATA_WIDTH: data to the master `s_axis`.
- `m_tvalid_o` out 1: valid to the master.
- `m_tlast_o` out 1: last to the master.
- `m_tready_i` in 1: ready from the master.
- `s_tdata_i` in RSP_WIDTH: response data from the master `m_axis`.
- `s_tvalid_i` in 1: response valid.
- `s_tlast_i` in 1: response last beat.
- `s_tready_o` out 1: response ready to the master.
- `rsp_tdata_o` out NUM_REQ*RSP_WIDTH: response data per requester.
- `rsp_tvalid_o` out NUM_REQ: response valid per requester.
- `rsp_tlast_o` out NUM_REQ: response last per requester.
- `rsp_tready_i` in NUM_REQ: response ready per requester.
- `owner_o` out $clog2(NUM_REQ): index of the current grant holder.
- `busy_o` out 1: high whenever the arbiter is not in IDLE.

## Operation
- FSM states:
  - IDLE: no grant is held.
  - REQ: the grant holder's request packet is forwarded to the master.
  - RSP: the grant holder waits for the master's read response.
- IDLE -> REQ: taken when any `req_tvalid_i` bit is high. The winner is the first valid index strictly after `last_q`, searching modulo NUM_REQ. The winner is registered into `owner_q` and `last_q`. The read flag `rd_q` is latched from `req_tuser_i[winner]`.
- REQ: the owner's channel is passed through to the master:
  - `m_tdata_o`, `m_tvalid_o` and `m_tlast_o` are muxed from the owner.
  - `req_tready_o[owner] = m_tready_i`; all other ready bits are 0.
- REQ exit, on the owner's tlast handshake:
  - to RSP if `rd_q` is set;
  - otherwise to IDLE.
- RSP: the master's response is passed back to the owner:
  - `rsp_*[owner]` carries `s_*`, and `s_tready_o = rsp_tready_i[owner]`.
  - The state returns to IDLE on the response tlast handshake.
- Outside RSP, `s_tready_o` is 0 and every `rsp_tvalid_o` bit is 0. A response arriving outside RSP stalls; it is never dropped.
- Non-owner requesters see tready 0 for the full grant. Their beats are held upstream, not lost.
- A requester that deasserts tvalid mid-packet keeps the grant. The arbiter has no timeout.
- `req_tuser_i` on any beat after the first is ignored.
- Reset:
  - state = IDLE, `owner_q` = 0, `last_q` = NUM_REQ-1, `rd_q` = 0.
  - All tready and tvalid outputs are 0; `busy_o` = 0; `owner_o` = 0.
  - Consequence: after reset, requester 0 has the highest priority.
- Reset asserted mid-packet forces IDLE immediately. Partial packets are abandoned, and the master is reset by the same `arstn_i`.

## Timing
- Arbitration costs 1 cycle. A request whose tvalid is high in IDLE at edge n makes `m_tvalid_o` high from cycle n+1.
- Single-beat write: IDLE(n) -> REQ(n+1). With `m_tready_i` high, the handshake happens at n+1 and the FSM is back in IDLE at n+2. A pending requester can be granted again at n+3.
- The datapath is combinational through the mux, with zero added latency inside the grant. The only registers are state, `owner_q`, `last_q` and `rd_q`.
- Packet tlast and the REQ -> RSP transition share the same edge. A response beat can be accepted from the following cycle.
- Simultaneous requests from all ports are granted in the order `last_q`+1, `last_q`+2, ... One packet is served per grant.

## Test plan
- Reset, then only req1 sends a 2-beat write (0xA0_10, 0xA0_20 with tlast) -> grant at cycle 1, `owner_o`=1, both beats reach `m_tdata_o` in order, `busy_o` falls after the tlast handshake.
- req0, req1 and req2 hold tvalid together with NUM_REQ=3, each sending a 1-beat write -> grant order 0, 1, 2. Then req0 again -> grant to 0.
- req0 sends a read packet (tuser=1 on first beat, 0x0A_00 tlast) and the master returns 2 response beats 0x5A, 0xC3 with tlast -> only `rsp_tvalid_o[0]` asserts, and the grant is held until the second beat. req1, pending throughout, sees tready 0 until IDLE.
- `m_tready_i` toggles 1/0 during a 3-beat packet, and the owner drops tvalid for 2 cycles -> no beat is lost or duplicated, the grant is not released, and non-owners keep tready 0.
- `arstn_i` is asserted during beat 2 of a 3-beat packet -> all outputs return to reset values asynchronously. After release, the first grant goes to port 0 if it is valid.
- A response beat presented while in IDLE -> `s_tready_o`=0 and no `rsp_tvalid_o` bit asserts.
